serial_addsub: RTL

Bit-serial two's-complement adder/subtractor built around a single full-adder cell and a carry flip-flop, processing one bit per clock LSB-first. It sits beside the combinational full adder in the arithmetic lab set as the area-minimal sequential alternative. A start/done handshake drives it, and it reports result, carry/borrow and signed overflow.

---
 rtl/serial_addsub_if.sv | 27 ++
 rtl/serial_addsub.sv | 136 +++++++++++++
 2 files changed

// File: rtl/serial_addsub_if.sv
// Request/response bundle for the bit-serial adder/subtractor.
// The requester drives the operation fields and start; the datapath
// answers with busy/done and the registered result flags.
interface serial_addsub_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             carry_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;

   modport master (
      output start, sub, operand_a, operand_b, carry_in,
      input  busy, done, result, carry_out, overflow
   );

   modport slave (
      input  start, sub, operand_a, operand_b, carry_in,
      output busy, done, result, carry_out, overflow
   );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor.
// One full-adder cell plus a carry flop processes the operands LSB-first,
// one bit per clock. Subtraction is done as a + ~b + ~borrow_in by
// inverting B and the incoming carry at load time. Every output is a flop.
module serial_addsub #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           reset,
   serial_addsub_if.slave bus
);

   localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             c_q, c_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             sum_bit;
   logic             carry_nxt;

   // Sum output of the single full-adder cell.
   function automatic logic fa_sum(input logic x, input logic y, input logic ci);
      return x ^ y ^ ci;
   endfunction

   // Carry output of the full-adder cell (majority of the three inputs).
   function automatic logic fa_carry(input logic x, input logic y, input logic ci);
      return (x & y) | (x & ci) | (y & ci);
   endfunction

   // The one full-adder cell, fed from the shift-register LSBs and the carry flop.
   always_comb begin
      sum_bit   = fa_sum(a_q[0], b_q[0], c_q);
      carry_nxt = fa_carry(a_q[0], b_q[0], c_q);
   end

   // Next-state and datapath update: load on accepted start, shift in SHIFT.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE, DONE: begin
            // start is only honoured here; carry_out/overflow keep the
            // previous operation's flags until the next DONE.
            if (bus.start) begin
               a_d     = bus.operand_a;
               b_d     = bus.operand_b ^ {WIDTH{bus.sub}};
               c_d     = bus.carry_in ^ bus.sub;
               cnt_d   = '0;
               res_d   = '0;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end

         SHIFT: begin
            a_d   = {1'b0, a_q[WIDTH-1:1]};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
            res_d = {sum_bit, res_q[WIDTH-1:1]};
            c_d   = carry_nxt;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               // c_q is the carry into the MSB here, carry_nxt the carry out.
               cout_d  = carry_nxt;
               ovf_d   = c_q ^ carry_nxt;
               cnt_d   = '0;
               state_d = DONE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   // State, datapath and registered outputs; reset aborts everything at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result    = res_q;
   assign bus.carry_out = cout_q;
   assign bus.overflow  = ovf_q;

endmodule
